// File: rtl/p2n_pkg.sv
// Shared definitions for the perm-to-NOC response transmitter: command codes,
// FSM states and header byte construction.
package p2n_pkg;

    localparam logic [2:0] RD_RSP            = 3'b011;
    localparam logic [2:0] WR_RSP            = 3'b100;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        STAT
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [2:0] code, input logic [2:0] cmd);
        return {2'b00, code, cmd};
    endfunction

endpackage

// File: rtl/p2n_fifo.sv
// Synchronous byte FIFO with occupancy count, full/empty flags and a sticky
// overflow flag; active-low synchronous reset flushes it.
module p2n_fifo #(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign pop_data = mem[rd_ptr_reg];

    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + AW'(1);
            end
            if (push && !do_push) begin
                overflow_reg <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/p2n_tx.sv
// Response transmitter: serializes write acks and buffered read-data responses
// as header + payload byte frames toward the NOC.
module p2n_tx
    import p2n_pkg::*;
#(
    parameter int         FIFO_DEPTH = 128,
    parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       fifo_overflow,
    input  logic       rsp_valid,
    output logic       rsp_ready,
    input  logic       rsp_kind,
    input  logic [2:0] rsp_dlen_code,
    input  logic [7:0] rsp_status,
    output logic       noc_from_dev_ctl,
    output logic [7:0] noc_from_dev_data,
    output logic       busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_reg;
    logic          kind_reg;
    logic [2:0]    code_reg;
    logic [7:0]    status_reg;
    logic [7:0]    byte_cnt_reg;
    logic          ctl_reg;
    logic [7:0]    data_reg;

    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [7:0]    req_len;
    logic          accept;
    logic [2:0]    acc_code;

    p2n_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    assign req_len   = 8'd1 << rsp_dlen_code;
    assign rsp_ready = reset && (state_reg == IDLE) &&
                       (!rsp_kind || (32'(fifo_count) >= 32'(req_len)));
    assign accept    = rsp_valid && rsp_ready;
    assign acc_code  = rsp_kind ? rsp_dlen_code : 3'b000;

    // The output register is loaded one cycle ahead, so the pop that fetches a
    // payload byte happens on the edge that puts it on the bus.
    assign fifo_pop = !fifo_empty &&
                      (((state_reg == HDR) && kind_reg) ||
                       ((state_reg == DATA) && (byte_cnt_reg != 8'd1)));

    assign noc_from_dev_ctl  = ctl_reg;
    assign noc_from_dev_data = data_reg;
    assign busy              = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            kind_reg     <= 1'b0;
            code_reg     <= 3'b000;
            status_reg   <= 8'h00;
            byte_cnt_reg <= 8'h00;
            ctl_reg      <= 1'b1;
            data_reg     <= IDLE_BYTE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        kind_reg   <= rsp_kind;
                        code_reg   <= acc_code;
                        status_reg <= rsp_status;
                        state_reg  <= HDR;
                        ctl_reg    <= 1'b1;
                        data_reg   <= hdr_byte(acc_code, rsp_kind ? RD_RSP : WR_RSP);
                    end
                end
                HDR: begin
                    ctl_reg <= 1'b0;
                    if (kind_reg) begin
                        state_reg    <= DATA;
                        byte_cnt_reg <= 8'd1 << code_reg;
                        data_reg     <= fifo_rd_data;
                    end else begin
                        state_reg <= STAT;
                        data_reg  <= status_reg;
                    end
                end
                DATA: begin
                    if (byte_cnt_reg == 8'd1) begin
                        state_reg <= IDLE;
                        ctl_reg   <= 1'b1;
                        data_reg  <= IDLE_BYTE;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg - 8'd1;
                        data_reg     <= fifo_rd_data;
                    end
                end
                STAT: begin
                    state_reg <= IDLE;
                    ctl_reg   <= 1'b1;
                    data_reg  <= IDLE_BYTE;
                end
                default: begin
                    state_reg <= IDLE;
                    ctl_reg   <= 1'b1;
                    data_reg  <= IDLE_BYTE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2n_tx.sv
// Bench for p2n_tx: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the frame stream and payload buffer.
module tb_p2n_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rsp_valid = 1'b0;
    logic       rsp_kind = 1'b0;
    logic [2:0] rsp_dlen_code = 3'b000;
    logic [7:0] rsp_status = 8'h00;
    logic       fifo_full;
    logic       fifo_overflow;
    logic       rsp_ready;
    logic       noc_from_dev_ctl;
    logic [7:0] noc_from_dev_data;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: payload bytes waiting, and the queue of bus cycles still to emit
    // (-1 = next payload byte, otherwise {ctl,data}).
    logic [7:0] q[$];
    int         plan[$];
    bit         m_ovf  = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_ctl  = 1'b1;
    logic [7:0] m_data = 8'h00;

    always #5 clk = ~clk;

    p2n_tx #(.FIFO_DEPTH(128), .IDLE_BYTE(8'h00)) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .fifo_full         (fifo_full),
        .fifo_overflow     (fifo_overflow),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_kind          (rsp_kind),
        .rsp_dlen_code     (rsp_dlen_code),
        .rsp_status        (rsp_status),
        .noc_from_dev_ctl  (noc_from_dev_ctl),
        .noc_from_dev_data (noc_from_dev_data),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return reset && !m_busy && (!rsp_kind || (q.size() >= (1 << rsp_dlen_code)));
    endfunction

    task automatic model_edge();
        int tok;
        if (!reset) begin
            q.delete();
            plan.delete();
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            m_ctl  = 1'b1;
            m_data = 8'h00;
            return;
        end
        if (rsp_valid && m_ready()) begin
            $display("[TB] accept kind=%0d code=%0d status=%02h t=%0t",
                     rsp_kind, rsp_dlen_code, rsp_status, $time);
            if (rsp_kind) begin
                plan.push_back(256 + rsp_dlen_code * 8 + 3);
                for (int i = 0; i < (1 << rsp_dlen_code); i++) plan.push_back(-1);
            end else begin
                plan.push_back(256 + 4);
                plan.push_back(int'(rsp_status));
            end
        end
        if (plan.size() > 0) begin
            tok    = plan.pop_front();
            m_busy = 1'b1;
            if (tok < 0) begin
                m_ctl  = 1'b0;
                m_data = q.pop_front();
            end else begin
                m_ctl  = tok[8];
                m_data = tok[7:0];
            end
        end else begin
            m_busy = 1'b0;
            m_ctl  = 1'b1;
            m_data = 8'h00;
        end
        if (wr_en) begin
            if (q.size() < 128) q.push_back(wr_data);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        #1;
        check("rsp_ready", rsp_ready, m_ready());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("ctl", noc_from_dev_ctl, m_ctl);
        check("data", noc_from_dev_data, m_data);
        check("busy", busy, m_busy);
        check("fifo_full", fifo_full, q.size() == 128);
        check("fifo_overflow", fifo_overflow, m_ovf);
    endtask

    task automatic expect_out(input string tag, input logic c, input logic [7:0] d);
        check({tag, "_ctl"}, noc_from_dev_ctl, c);
        check({tag, "_data"}, noc_from_dev_data, d);
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
    endtask

    logic [7:0] t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Write ack with status 5A
        rsp_valid = 1'b1; rsp_kind = 1'b0; rsp_status = 8'h5A;
        tick(); expect_out("t1_hdr", 1'b1, 8'h04);
        rsp_valid = 1'b0;
        tick(); expect_out("t1_stat", 1'b0, 8'h5A);
        tick(); expect_out("t1_idle", 1'b1, 8'h00);

        // Read of 4 buffered bytes
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = t2[i]; tick();
        end
        wr_en = 1'b0;
        rsp_valid = 1'b1; rsp_kind = 1'b1; rsp_dlen_code = 3'd2;
        tick(); expect_out("t2_hdr", 1'b1, 8'h13);
        rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("t2_pay", 1'b0, t2[i]);
        end
        tick(); expect_out("t2_idle", 1'b1, 8'h00);

        // Read of 8 bytes while only 5 are buffered
        push_bytes(5);
        rsp_valid = 1'b1; rsp_kind = 1'b1; rsp_dlen_code = 3'd3;
        push_bytes(3);
        tick(); expect_out("t3_hdr", 1'b1, 8'h1B);
        rsp_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); check("t3_ctl", noc_from_dev_ctl, 1'b0);
        end
        tick(); expect_out("t3_idle", 1'b1, 8'h00);

        // Write ack immediately followed by a 128-byte read
        push_bytes(126);
        rsp_valid = 1'b1; rsp_kind = 1'b0; rsp_status = 8'hC3;
        wr_en = 1'b1; wr_data = 8'($urandom);
        tick(); expect_out("t4_ack_hdr", 1'b1, 8'h04);
        rsp_kind = 1'b1; rsp_dlen_code = 3'd7; wr_data = 8'($urandom);
        tick(); expect_out("t4_ack_stat", 1'b0, 8'hC3);
        wr_en = 1'b0;
        tick(); expect_out("t4_gap", 1'b1, 8'h00);
        tick(); expect_out("t4_rd_hdr", 1'b1, 8'h3B);
        rsp_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tick(); check("t4_ctl", noc_from_dev_ctl, 1'b0);
        end
        tick(); expect_out("t4_idle", 1'b1, 8'h00);

        // Overflow: fill to 128, then one extra push
        push_bytes(128);
        check("t5_full", fifo_full, 1'b1);
        check("t5_no_ovf", fifo_overflow, 1'b0);
        wr_en = 1'b1; wr_data = 8'hEE; tick(); wr_en = 1'b0;
        check("t5_ovf", fifo_overflow, 1'b1);
        check("t5_full2", fifo_full, 1'b1);
        rsp_valid = 1'b1; rsp_kind = 1'b1; rsp_dlen_code = 3'd7;
        tick(); rsp_valid = 1'b0;
        repeat (129) tick();
        check("t5_ovf_sticky", fifo_overflow, 1'b1);

        // Reset during the 3rd payload byte
        push_bytes(8);
        rsp_valid = 1'b1; rsp_kind = 1'b1; rsp_dlen_code = 3'd3;
        tick(); rsp_valid = 1'b0;
        repeat (3) tick();
        check("t6_mid", noc_from_dev_ctl, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("t6_rst", 1'b1, 8'h00);
        check("t6_busy", busy, 1'b0);
        check("t6_ovf", fifo_overflow, 1'b0);
        reset = 1'b1;
        rsp_valid = 1'b1; rsp_kind = 1'b1; rsp_dlen_code = 3'd0;
        #1; check("t6_empty", rsp_ready, 1'b0);
        tick(); rsp_valid = 1'b0;
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom % 300) != 0;
            rsp_valid     = ($urandom % 4) == 0;
            rsp_kind      = 1'($urandom % 2);
            rsp_dlen_code = (($urandom % 8) == 0) ? 3'($urandom % 8) : 3'($urandom % 3);
            rsp_status    = 8'($urandom);
            wr_en         = ($urandom % 3) != 0;
            wr_data       = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
